// File: rtl/fifo_byte_packer_if.sv
// Handshake bundle between the 12-bit sample FIFO, the byte packer and the byte transmitter.
// The packer side is the master; the FIFO and transmitter side is the slave.
interface fifo_byte_packer_if;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned BYTE_W   = 8;

    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_data;
    logic                fifo_rd_en;
    logic [BYTE_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/fifo_byte_packer.sv
// Pops 12-bit samples from a FIFO and packs each pair into three big-endian bytes.
// A flush pushes out a lone held sample as two bytes with the low nibble zero-padded.
module fifo_byte_packer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    fifo_byte_packer_if.master  bus,
    input  logic                flush,
    output logic                busy,
    output logic [CNT_W-1:0]    grp_cnt
);
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [3:0] {
        GET_A, WAIT_A, GET_B, WAIT_B, SEND0, SEND1, SEND2, FL0, FL1
    } state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] a_q, a_d;
    logic [SAMPLE_W-1:0] b_q, b_d;
    logic [BYTE_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]    grp_q, grp_d;
    logic                busy_q, busy_d;
    logic                pop_c;
    logic                hs_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= GET_A;
            a_q          <= '0;
            b_q          <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            grp_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
            grp_q        <= grp_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, pop request and next output byte
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        grp_d        = grp_q;
        flush_pend_d = flush_pend_q | flush;
        pop_c        = 1'b0;
        hs_c         = out_valid_q & bus.out_ready;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;

        case (state_q)
            GET_A: begin
                // Nothing is held here, so only a flush arriving this very cycle survives
                flush_pend_d = flush;
                if (!bus.fifo_empty) begin
                    pop_c   = 1'b1;
                    state_d = WAIT_A;
                end
            end
            WAIT_A: begin
                a_d     = bus.fifo_data;
                state_d = GET_B;
            end
            GET_B: begin
                if (!bus.fifo_empty) begin
                    pop_c   = 1'b1;
                    state_d = WAIT_B;
                end else if (flush_pend_q) begin
                    state_d = FL0;
                end
            end
            WAIT_B: begin
                b_d     = bus.fifo_data;
                state_d = SEND0;
            end
            SEND0: if (hs_c) state_d = SEND1;
            SEND1: if (hs_c) state_d = SEND2;
            SEND2: begin
                if (hs_c) begin
                    grp_d   = grp_q + CNT_W'(1);
                    state_d = GET_A;
                end
            end
            FL0: if (hs_c) state_d = FL1;
            FL1: begin
                if (hs_c) begin
                    grp_d        = grp_q + CNT_W'(1);
                    flush_pend_d = flush;
                    state_d      = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase

        // Byte for the state being entered; a and b are already settled by then
        case (state_d)
            SEND0: begin
                out_valid_d = 1'b1;
                out_data_d  = a_q[11:4];
            end
            SEND1: begin
                out_valid_d = 1'b1;
                out_data_d  = {a_q[3:0], b_q[11:8]};
            end
            SEND2: begin
                out_valid_d = 1'b1;
                out_data_d  = b_q[7:0];
            end
            FL0: begin
                out_valid_d = 1'b1;
                out_data_d  = a_q[11:4];
            end
            FL1: begin
                out_valid_d = 1'b1;
                out_data_d  = {a_q[3:0], 4'h0};
            end
            default: begin
                out_valid_d = 1'b0;
                out_data_d  = out_data_q;
            end
        endcase

        busy_d = (state_d != GET_A) | flush_pend_d;
    end

    assign bus.fifo_rd_en = pop_c & rst;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign busy           = busy_q;
    assign grp_cnt        = grp_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: table of sample pairs plus hand-written flush, stall and reset sequences.
module tb_fifo_byte_packer;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             flush = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] grp_cnt;

    fifo_byte_packer_if bus();

    fifo_byte_packer #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .flush   (flush),
        .busy    (busy),
        .grp_cnt (grp_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered data output, valid the cycle after a pop
    logic [11:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_data <= mem[rd_ptr % 64];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Monitor: accepted bytes, pops and back-to-back pop violations
    int          cyc = 0;
    logic [7:0]  bytes    [0:255];
    int          byte_cyc [0:255];
    int          nbytes = 0;
    int          pop_cyc  [0:255];
    int          npops = 0;
    logic        prev_rd = 1'b0;
    int          dbl_pop = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_rd <= bus.fifo_rd_en;
        if (bus.fifo_rd_en) begin
            pop_cyc[npops % 256] <= cyc;
            npops <= npops + 1;
            if (prev_rd) dbl_pop <= dbl_pop + 1;
        end
        if (rst && bus.out_valid && bus.out_ready) begin
            bytes[nbytes % 256]    <= bus.out_data;
            byte_cyc[nbytes % 256] <= cyc;
            nbytes <= nbytes + 1;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [11:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int k;
        k = 0;
        while (nbytes < target && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(name, (nbytes >= target) ? 1 : 0, 1);
    endtask

    vec_t vecs [4];
    int   exp_grp;
    int   b0;
    int   p0;
    int   vcnt;

    initial begin
        vecs[0] = '{a: 12'hABC, b: 12'h123, e0: 8'hAB, e1: 8'hC1, e2: 8'h23};
        vecs[1] = '{a: 12'h5A5, b: 12'hA5A, e0: 8'h5A, e1: 8'h5A, e2: 8'h5A};
        vecs[2] = '{a: 12'hFFF, b: 12'h000, e0: 8'hFF, e1: 8'hF0, e2: 8'h00};
        vecs[3] = '{a: 12'h3C7, b: 12'h8E1, e0: 8'h3C, e1: 8'h78, e2: 8'hE1};
        exp_grp = 0;
        bus.out_ready = 1'b1;

        // Reset with a word already waiting: no pop may leak out
        push(12'h5A7);
        tick(2);
        check("reset_rd_en", 32'(bus.fifo_rd_en), 0);
        check("reset_valid", 32'(bus.out_valid), 0);
        check("reset_data", 32'(bus.out_data), 0);
        check("reset_grp", 32'(grp_cnt), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b1;

        // Lone sample waits indefinitely, then flush emits two bytes
        tick(10);
        check("lone_no_bytes", nbytes, 0);
        check("lone_busy", 32'(busy), 1);
        check("lone_pops", npops, 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_bytes(2, "flush_done");
        check("flush_b0", 32'(bytes[0]), 32'h5A);
        check("flush_b1", 32'(bytes[1]), 32'h70);
        exp_grp++;
        check("flush_grp", 32'(grp_cnt), exp_grp);
        tick(2);
        check("flush_idle_busy", 32'(busy), 0);
        check("flush_idle_valid", 32'(bus.out_valid), 0);

        // Flush with nothing held produces nothing
        b0 = nbytes;
        p0 = npops;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
        check("empty_flush_busy", 32'(busy), 0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) vcnt++;
            tick(1);
        end
        check("empty_flush_valid", vcnt, 0);
        check("empty_flush_bytes", nbytes - b0, 0);
        check("empty_flush_grp", 32'(grp_cnt), exp_grp);
        check("empty_flush_pops", npops - p0, 0);

        // Table of pairs with full-rate acceptance
        for (int v = 0; v < 4; v++) begin
            b0 = nbytes;
            p0 = npops;
            push(vecs[v].a);
            push(vecs[v].b);
            wait_bytes(b0 + 3, $sformatf("vec%0d_done", v));
            tick(2);
            exp_grp++;
            check($sformatf("vec%0d_b0", v), 32'(bytes[b0]), 32'(vecs[v].e0));
            check($sformatf("vec%0d_b1", v), 32'(bytes[b0 + 1]), 32'(vecs[v].e1));
            check($sformatf("vec%0d_b2", v), 32'(bytes[b0 + 2]), 32'(vecs[v].e2));
            check($sformatf("vec%0d_pops", v), npops - p0, 2);
            check($sformatf("vec%0d_pop_gap", v), pop_cyc[p0 + 1] - pop_cyc[p0], 2);
            check($sformatf("vec%0d_lat_first", v), byte_cyc[b0] - pop_cyc[p0], 4);
            check($sformatf("vec%0d_lat_last", v), byte_cyc[b0 + 2] - pop_cyc[p0], 6);
            check($sformatf("vec%0d_grp", v), 32'(grp_cnt), exp_grp);
            check($sformatf("vec%0d_busy", v), 32'(busy), 0);
        end

        // Back-to-back pairs: next pop one cycle after the last byte
        b0 = nbytes;
        p0 = npops;
        push(12'h111);
        push(12'h222);
        push(12'h333);
        push(12'h444);
        wait_bytes(b0 + 6, "b2b_done");
        tick(2);
        exp_grp += 2;
        check("b2b_next_pop", pop_cyc[p0 + 2] - byte_cyc[b0 + 2], 1);
        check("b2b_b3", 32'(bytes[b0 + 3]), 32'h33);
        check("b2b_b5", 32'(bytes[b0 + 5]), 32'h44);
        check("b2b_grp", 32'(grp_cnt), exp_grp);

        // Stall during the middle byte
        b0 = nbytes;
        p0 = npops;
        push(12'hABC);
        push(12'h123);
        wait_bytes(b0 + 1, "stall_first");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), 32'(bus.out_valid), 1);
            check($sformatf("stall%0d_data", i), 32'(bus.out_data), 32'hC1);
            tick(1);
        end
        check("stall_pops", npops - p0, 2);
        bus.out_ready = 1'b1;
        wait_bytes(b0 + 3, "stall_done");
        tick(1);
        exp_grp++;
        check("stall_b1", 32'(bytes[b0 + 1]), 32'hC1);
        check("stall_b2", 32'(bytes[b0 + 2]), 32'h23);
        check("stall_grp", 32'(grp_cnt), exp_grp);

        // Flush and new data in the same cycle while one sample is held: data wins
        b0 = nbytes;
        push(12'h001);
        tick(4);
        flush = 1'b1;
        push(12'hFFF);
        tick(1);
        flush = 1'b0;
        wait_bytes(b0 + 3, "dwin_done");
        exp_grp++;
        check("dwin_b0", 32'(bytes[b0]), 32'h00);
        check("dwin_b1", 32'(bytes[b0 + 1]), 32'h1F);
        check("dwin_b2", 32'(bytes[b0 + 2]), 32'hFF);
        tick(3);
        check("dwin_busy", 32'(busy), 0);
        tick(10);
        check("dwin_no_extra", nbytes - b0, 3);
        check("dwin_grp", 32'(grp_cnt), exp_grp);

        // Asynchronous reset in the middle of a group
        b0 = nbytes;
        push(12'hABC);
        push(12'h123);
        wait_bytes(b0 + 1, "rst_first");
        bus.out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_grp", 32'(grp_cnt), 0);
        check("arst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        exp_grp = 0;
        tick(3);
        check("arst_no_resume", nbytes - b0, 1);
        b0 = nbytes;
        push(12'h800);
        push(12'h00F);
        wait_bytes(b0 + 3, "arst_pair_done");
        exp_grp++;
        check("arst_b0", 32'(bytes[b0]), 32'h80);
        check("arst_b1", 32'(bytes[b0 + 1]), 32'h00);
        check("arst_b2", 32'(bytes[b0 + 2]), 32'h0F);
        tick(1);
        check("arst_grp_after", 32'(grp_cnt), exp_grp);

        check("no_double_pop", dbl_pop, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_byte_packer.md
Name: fifo_byte_packer

Overview:
Downstream consumer of the 12-bit sample FIFO. It pops 12-bit words through the FIFO's rd_en/empty interface and packs each pair of samples into three bytes, big-endian. The bytes go out on a valid/ready byte stream feeding the UART/byte transmitter. A flush request forces out a lone held sample as two bytes, zero-padded.

Parameters:
CNT_W, 16, width of the completed-group counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
fifo_empty  input  1  FIFO empty flag
fifo_data  input  12  FIFO data_out; registered, valid the cycle after a pop
fifo_rd_en  output  1  pop request to FIFO; combinational from state and fifo_empty
flush  input  1  single-cycle pulse: emit any held odd sample
out_data  output  8  byte to transmitter
out_valid  output  1  out_data valid; held until accepted
out_ready  input  1  transmitter accepts byte when out_valid && out_ready at a clock edge
busy  output  1  high in any state other than GET_A, or when flush_pend=1
grp_cnt  output  CNT_W  count of emitted groups (3-byte pairs and 2-byte flushes), wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - state=GET_A; a_reg=b_reg=0; out_data=0; out_valid=0; flush_pend=0; grp_cnt=0.
  - fifo_rd_en=0 while in reset.
  - Reset mid-operation discards held samples and any partially sent group; no resumption.
- FIFO pop rule:
  - fifo_rd_en=1 only in GET_A or GET_B, and only when fifo_empty=0. It is never high for two consecutive cycles.
  - fifo_data is captured in the cycle after the pop (WAIT_A/WAIT_B).
- States:
  - GET_A: if !fifo_empty, pop and go WAIT_A. Otherwise stay. flush_pend is cleared every cycle in this state (nothing held).
  - WAIT_A: a_reg<=fifo_data; go GET_B.
  - GET_B: if !fifo_empty, pop and go WAIT_B (data has priority over flush). Else if flush_pend, go FL0. Else stay, indefinitely.
  - WAIT_B: b_reg<=fifo_data; go SEND0.
  - SEND0/SEND1/SEND2: out_valid=1 with out_data = a_reg[11:4], then {a_reg[3:0],b_reg[11:8]}, then b_reg[7:0]. Advance on handshake. After SEND2's handshake: grp_cnt+1, go GET_A.
  - FL0/FL1: out_data = a_reg[11:4], then {a_reg[3:0],4'h0}. Advance on handshake. After FL1's handshake: grp_cnt+1, clear flush_pend, go GET_A.
- out_valid and out_data are registered. out_data must not change while out_valid=1 and out_ready=0.
- Byte-to-byte transitions: on a handshake, the next byte is presented in the following cycle with out_valid still 1. There is no bubble within a group.
- Flush request:
  - flush=1 in any cycle sets flush_pend. It is consumed only in GET_B (lone sample held).
  - In GET_A it is cleared immediately with no output.
  - A flush arriving during SEND*/WAIT_B stays set; it is cleared on return to GET_A.
- Latency (FIFO already holding ≥2 words, out_ready=1): pop A at cycle 0, pop B at cycle 2, first byte valid at cycle 4. The last byte is accepted at cycle 6, and the next pop happens at cycle 7. Sustained rate is 3 bytes per 7 cycles.
- grp_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- FIFO preloaded 0xABC, 0x123; out_ready=1 → bytes 0xAB, 0xC1, 0x23 on consecutive cycles starting 4 cycles after first fifo_rd_en; exactly two fifo_rd_en pulses; grp_cnt=1.
- Same data, out_ready low for 5 cycles during SEND1 → out_data holds 0xC1 with out_valid=1 throughout; no extra pops; sequence completes after out_ready returns.
- Push 0x5A7 only, wait 10 cycles (no output, busy=1), pulse flush → bytes 0x5A, 0x70; grp_cnt=1; state returns to GET_A.
- flush pulse with FIFO empty and nothing held → no out_valid for 20 cycles; grp_cnt stays 0; busy returns to 0 next cycle.
- Push 0x001, flush and push 0xFFF in the same cycle → data wins: bytes 0x00, 0x1F, 0xFF; flush_pend cleared afterwards; no flush bytes emitted.
- Assert rst during SEND1 → out_valid=0 and grp_cnt=0 immediately (asynchronous). After release, new pair 0x800, 0x00F → 0x80, 0x00, 0x0F.
